// File: rtl/timer_alarm_pkg.sv
// Shared register map, CTRL bit positions and alarm FSM encoding for timer_alarm.
package timer_alarm_pkg;

   localparam int unsigned REG_IDX_W = 3;
   localparam int unsigned CTRL_W    = 3;

   localparam logic [REG_IDX_W-1:0] REG_CTRL     = 3'd0;
   localparam logic [REG_IDX_W-1:0] REG_DIV      = 3'd1;
   localparam logic [REG_IDX_W-1:0] REG_COUNT_LO = 3'd2;
   localparam logic [REG_IDX_W-1:0] REG_HI_SNAP  = 3'd3;
   localparam logic [REG_IDX_W-1:0] REG_CMP_LO   = 3'd4;
   localparam logic [REG_IDX_W-1:0] REG_CMP_HI   = 3'd5;
   localparam logic [REG_IDX_W-1:0] REG_PERIOD   = 3'd6;
   localparam logic [REG_IDX_W-1:0] REG_STATUS   = 3'd7;

   localparam int unsigned CTRL_EN     = 0;
   localparam int unsigned CTRL_PER    = 1;
   localparam int unsigned CTRL_IRQ_EN = 2;

   typedef enum logic [1:0] {
      ST_DISARMED = 2'd0,
      ST_ARMED    = 2'd1,
      ST_FIRED    = 2'd2
   } alarm_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by (div+1); tick_c is high on the cycle whose edge wraps the prescaler.
module tick_prescaler #(
   parameter int unsigned DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             clear,
   input  logic [DIV_W-1:0] div,
   output logic             tick_c
);

   logic [DIV_W-1:0] cnt;

   // A clearing write owns the cycle, so no tick is issued alongside it.
   assign tick_c = enable && !clear && (cnt == div);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= (cnt == div) ? '0 : cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/timer_alarm.sv
// Memory-mapped 64-bit tick counter with tear-free reads and a one-shot/periodic
// compare alarm driving a level interrupt.
module timer_alarm #(
   parameter int unsigned DEFAULT_DIV = 49,
   parameter int unsigned DIV_W       = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        we,
   input  logic        re,
   input  logic [4:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);
   import timer_alarm_pkg::*;

   logic [REG_IDX_W-1:0] idx;
   logic [1:0]           unused_addr;
   logic                 wr_c, rd_c;
   logic                 ctrl_wr_c, div_wr_c, cntlo_wr_c, cmp_wr_c, cmp_hi_wr_c, w1c_c;
   logic                 tick_c, match_c, fire_c, reload_c;

   logic [CTRL_W-1:0]    ctrl;
   logic [DIV_W-1:0]     div;
   logic [63:0]          count;
   logic [63:0]          cmp;
   logic [31:0]          hi_snap;
   logic [31:0]          period;
   logic                 pending;
   alarm_state_t         state, state_nx;

   assign idx         = addr[4:2];
   assign unused_addr = addr[1:0];
   assign wr_c        = en && we;
   assign rd_c        = en && re;
   assign ctrl_wr_c   = wr_c && (idx == REG_CTRL);
   assign div_wr_c    = wr_c && (idx == REG_DIV);
   assign cntlo_wr_c  = wr_c && (idx == REG_COUNT_LO);
   assign cmp_hi_wr_c = wr_c && (idx == REG_CMP_HI);
   assign cmp_wr_c    = cmp_hi_wr_c || (wr_c && (idx == REG_CMP_LO));
   assign w1c_c       = wr_c && (idx == REG_STATUS) && wdata[0];
   assign match_c     = (count >= cmp);
   assign irq         = pending && ctrl[CTRL_IRQ_EN];

   tick_prescaler #(.DIV_W(DIV_W)) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .enable (ctrl[CTRL_EN]),
      .clear  (div_wr_c || cntlo_wr_c),
      .div    (div),
      .tick_c (tick_c)
   );

   // Register file, counter and snapshot.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl    <= '0;
         div     <= DIV_W'(DEFAULT_DIV);
         count   <= '0;
         cmp     <= '0;
         hi_snap <= '0;
         period  <= '0;
         pending <= 1'b0;
      end else begin
         if (ctrl_wr_c) ctrl <= wdata[CTRL_W-1:0];
         if (div_wr_c) div <= wdata[DIV_W-1:0];
         if (wr_c && (idx == REG_PERIOD)) period <= wdata;
         if (rd_c && (idx == REG_COUNT_LO)) hi_snap <= count[63:32];

         if (cntlo_wr_c) count <= {32'd0, wdata};
         else if (tick_c) count <= count + 64'd1;

         if (wr_c && (idx == REG_CMP_LO)) cmp[31:0] <= wdata;
         else if (cmp_hi_wr_c) cmp[63:32] <= wdata;
         else if (reload_c) cmp <= cmp + {32'd0, period};

         // A new match beats a same-cycle clear.
         if (fire_c) pending <= 1'b1;
         else if (w1c_c) pending <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_DISARMED;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (ctrl_wr_c && !wdata[CTRL_EN]) begin
         state_nx = ST_DISARMED;
      end else if (cmp_hi_wr_c && ctrl[CTRL_EN]) begin
         state_nx = ST_ARMED;
      end else begin
         case (state)
            ST_ARMED: if (fire_c && !ctrl[CTRL_PER]) state_nx = ST_FIRED;
            ST_FIRED: if (w1c_c) state_nx = ST_DISARMED;
            default:  state_nx = state;
         endcase
      end
   end

   // A compare write this cycle defers the match to the new value.
   always_comb begin
      fire_c   = 1'b0;
      reload_c = 1'b0;
      if ((state == ST_ARMED) && match_c && !cmp_wr_c) begin
         fire_c   = 1'b1;
         reload_c = ctrl[CTRL_PER];
      end
   end

   always_comb begin
      rdata = '0;
      unique case (idx)
         REG_CTRL:     rdata = 32'(ctrl);
         REG_DIV:      rdata = 32'(div);
         REG_COUNT_LO: rdata = count[31:0];
         REG_HI_SNAP:  rdata = hi_snap;
         REG_CMP_LO:   rdata = cmp[31:0];
         REG_CMP_HI:   rdata = cmp[63:32];
         REG_PERIOD:   rdata = period;
         REG_STATUS:   rdata = 32'({state, pending});
      endcase
   end

endmodule

// File: tb/tb_timer_alarm.sv
// Directed test-plan scenarios plus randomized bus traffic checked against a reference model.
module tb_timer_alarm;

   localparam logic [2:0] I_CTRL = 3'd0, I_DIV = 3'd1, I_CNTLO = 3'd2, I_SNAP = 3'd3;
   localparam logic [2:0] I_CMPLO = 3'd4, I_CMPHI = 3'd5, I_PERIOD = 3'd6, I_STATUS = 3'd7;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en = 1'b0, we = 1'b0, re = 1'b0;
   logic [4:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        irq;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   timer_alarm #(.DEFAULT_DIV(49), .DIV_W(16)) dut (
      .clk(clk), .reset(reset), .en(en), .we(we), .re(re),
      .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq)
   );

   // Reference model: register contents and a tick phase advanced once per clock.
   logic [2:0]  m_ctrl;
   logic [15:0] m_div, m_ps;
   logic [63:0] m_count, m_cmp;
   logic [31:0] m_snap, m_period;
   logic        m_pend;
   int          m_st;

   task automatic m_clear();
      m_ctrl = '0; m_div = 16'd49; m_ps = '0; m_count = '0; m_cmp = '0;
      m_snap = '0; m_period = '0; m_pend = 1'b0; m_st = 0;
   endtask

   task automatic m_step();
      logic [2:0] i;
      logic w, r, tick, cmp_w, w1c, hit;
      i     = addr[4:2];
      w     = en & we;
      r     = en & re;
      tick  = m_ctrl[0] && (m_ps == m_div);
      cmp_w = w && (i == I_CMPLO || i == I_CMPHI);
      w1c   = w && (i == I_STATUS) && wdata[0];
      hit   = (m_st == 1) && (m_count >= m_cmp) && !cmp_w;
      if (r && i == I_CNTLO) m_snap = m_count[63:32];
      if (w && i == I_CNTLO) begin m_count = {32'd0, wdata}; m_ps = '0; end
      else if (w && i == I_DIV) m_ps = '0;
      else if (tick) begin m_ps = '0; m_count = m_count + 64'd1; end
      else if (m_ctrl[0]) m_ps = m_ps + 16'd1;
      if (hit) m_pend = 1'b1;
      else if (w1c) m_pend = 1'b0;
      if (w && i == I_CTRL && !wdata[0]) m_st = 0;
      else if (w && i == I_CMPHI && m_ctrl[0]) m_st = 1;
      else if (m_st == 1 && hit && !m_ctrl[1]) m_st = 2;
      else if (m_st == 2 && w1c) m_st = 0;
      if (hit && m_ctrl[1]) m_cmp = m_cmp + {32'd0, m_period};
      if (w) begin
         case (i)
            I_CTRL:   m_ctrl = wdata[2:0];
            I_DIV:    m_div = wdata[15:0];
            I_CMPLO:  m_cmp[31:0] = wdata;
            I_CMPHI:  m_cmp[63:32] = wdata;
            I_PERIOD: m_period = wdata;
            default:  ;
         endcase
      end
   endtask

   function automatic logic [31:0] m_read(input logic [2:0] i);
      case (i)
         I_CTRL:   return {29'd0, m_ctrl};
         I_DIV:    return {16'd0, m_div};
         I_CNTLO:  return m_count[31:0];
         I_SNAP:   return m_snap;
         I_CMPLO:  return m_cmp[31:0];
         I_CMPHI:  return m_cmp[63:32];
         I_PERIOD: return m_period;
         default:  return {29'd0, 2'(m_st), m_pend};
      endcase
   endfunction

   initial begin
      m_clear();
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) m_clear();
         else m_step();
      end
   end

   task automatic wr_reg(input logic [2:0] i, input logic [31:0] d);
      en = 1'b1; we = 1'b1; addr = {i, 2'b00}; wdata = d;
      @(negedge clk);
      en = 1'b0; we = 1'b0;
   endtask

   task automatic rd_reg(input logic [2:0] i, output logic [31:0] d);
      en = 1'b1; re = 1'b1; addr = {i, 2'b00};
      #1 d = rdata;
      @(negedge clk);
      en = 1'b0; re = 1'b0;
   endtask

   task automatic peek(input logic [2:0] i, output logic [31:0] d);
      addr = {i, 2'b00};
      #1 d = rdata;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      peek(I_DIV, d);
      n_vec++; if (d !== 32'd49) begin n_err++; $display("FAIL reset_div got %0d want 49", d); end
      peek(I_STATUS, d);
      n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_status got %0h want 0", d); end
      peek(I_CTRL, d);
      n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_ctrl got %0h want 0", d); end
      for (int k = 0; k < 100; k++) begin
         @(negedge clk); #1;
         n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq cycle %0d got %b want 0", k, irq); end
      end
   endtask

   task automatic test_count();
      logic [31:0] d;
      @(negedge clk);
      wr_reg(I_DIV, 32'd3);
      wr_reg(I_CTRL, 32'd1);
      repeat (40) @(negedge clk);
      rd_reg(I_CNTLO, d);
      n_vec++; if (d !== 32'd10) begin n_err++; $display("FAIL count_div3 got %0d want 10", d); end
      rd_reg(I_SNAP, d);
      n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL count_snap got %0d want 0", d); end
   endtask

   task automatic test_wrap();
      logic [31:0] d;
      wr_reg(I_CTRL, 32'd0);
      wr_reg(I_DIV, 32'd0);
      wr_reg(I_CNTLO, 32'hFFFF_FFFE);
      rd_reg(I_CNTLO, d);
      n_vec++; if (d !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL wrap_load got %0h want fffffffe", d); end
      rd_reg(I_SNAP, d);
      n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL wrap_hi_cleared got %0h want 0", d); end
      wr_reg(I_CTRL, 32'd1);
      repeat (2) @(negedge clk);
      rd_reg(I_CNTLO, d);
      n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL wrap_lo got %0h want 0", d); end
      rd_reg(I_SNAP, d);
      n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL wrap_carry got %0h want 1", d); end
      repeat (10) @(negedge clk);
      peek(I_SNAP, d);
      n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL snap_stable got %0h want 1", d); end
      wr_reg(I_CTRL, 32'd0);
      wr_reg(I_CNTLO, 32'd5);
      rd_reg(I_CNTLO, d);
      n_vec++; if (d !== 32'd5) begin n_err++; $display("FAIL reload_lo got %0h want 5", d); end
      rd_reg(I_SNAP, d);
      n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL reload_hi got %0h want 0", d); end
   endtask

   task automatic test_oneshot();
      logic [31:0] d;
      do_reset();
      wr_reg(I_DIV, 32'd0);
      wr_reg(I_CMPLO, 32'd20);
      wr_reg(I_CTRL, 32'd5);
      wr_reg(I_CMPHI, 32'd0);
      peek(I_STATUS, d);
      n_vec++; if (d !== 32'd2) begin n_err++; $display("FAIL oneshot_armed got %0h want 2", d); end
      repeat (19) @(negedge clk);
      peek(I_CNTLO, d);
      n_vec++; if (d !== 32'd20 || irq !== 1'b0) begin n_err++; $display("FAIL oneshot_pre count %0d irq %b want 20 0", d, irq); end
      @(negedge clk);
      peek(I_STATUS, d);
      n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL oneshot_irq got %b want 1", irq); end
      n_vec++; if (d !== 32'd5) begin n_err++; $display("FAIL oneshot_fired got %0h want 5", d); end
      wr_reg(I_STATUS, 32'd1);
      peek(I_STATUS, d);
      n_vec++; if (irq !== 1'b0 || d !== 32'd0) begin n_err++; $display("FAIL oneshot_w1c irq %b status %0h want 0 0", irq, d); end
   endtask

   task automatic test_periodic();
      logic [31:0] d;
      do_reset();
      wr_reg(I_DIV, 32'd0);
      wr_reg(I_CMPLO, 32'd10);
      wr_reg(I_PERIOD, 32'd5);
      wr_reg(I_CTRL, 32'd7);
      wr_reg(I_CMPHI, 32'd0);
      repeat (9) @(negedge clk); #1;
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL per_pre10 got %b want 0", irq); end
      @(negedge clk); #1;
      n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL per_hit10 got %b want 1", irq); end
      wr_reg(I_STATUS, 32'd1); #1;
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL per_clear10 got %b want 0", irq); end
      repeat (3) @(negedge clk); #1;
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL per_pre15 got %b want 0", irq); end
      wr_reg(I_STATUS, 32'd1);
      peek(I_STATUS, d);
      n_vec++; if (irq !== 1'b1 || d !== 32'd3) begin n_err++; $display("FAIL per_set_wins irq %b status %0h want 1 3", irq, d); end
      wr_reg(I_STATUS, 32'd1); #1;
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL per_clear15 got %b want 0", irq); end
      repeat (3) @(negedge clk); #1;
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL per_pre20 got %b want 0", irq); end
      @(negedge clk);
      peek(I_CMPLO, d);
      n_vec++; if (irq !== 1'b1 || d !== 32'd25) begin n_err++; $display("FAIL per_hit20 irq %b cmp %0d want 1 25", irq, d); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      do_reset();
      wr_reg(I_DIV, 32'd0);
      wr_reg(I_CMPLO, 32'd5);
      wr_reg(I_PERIOD, 32'd100);
      wr_reg(I_CTRL, 32'd7);
      wr_reg(I_CMPHI, 32'd0);
      repeat (6) @(negedge clk);
      peek(I_CNTLO, d);
      n_vec++; if (d !== 32'd7 || irq !== 1'b1) begin n_err++; $display("FAIL mid_pre count %0d irq %b want 7 1", d, irq); end
      addr = {I_DIV, 2'b00};
      #1 reset = 1'b0;
      #1;
      n_vec++; if (irq !== 1'b0 || rdata !== 32'd49) begin n_err++; $display("FAIL mid_async irq %b div %0d want 0 49", irq, rdata); end
      addr = {I_CNTLO, 2'b00};
      #1;
      n_vec++; if (rdata !== 32'd0) begin n_err++; $display("FAIL mid_count got %0d want 0", rdata); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_random();
      logic [2:0]  i;
      logic [31:0] d;
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         i = 3'($urandom_range(0, 7));
         case (i)
            I_CTRL:   d = {29'd0, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 7) != 0)};
            I_DIV:    d = $urandom_range(0, 3);
            I_CNTLO:  d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom_range(0, 63);
            I_CMPLO:  d = m_count[31:0] + $urandom_range(0, 40);
            I_CMPHI:  d = ($urandom_range(0, 7) == 0) ? 32'd1 : 32'd0;
            I_PERIOD: d = $urandom_range(0, 12);
            I_STATUS: d = $urandom_range(0, 1);
            default:  d = $urandom;
         endcase
         en = ($urandom_range(0, 99) < 40);
         we = 1'($urandom);
         re = 1'($urandom);
         addr = {i, 2'($urandom)};
         wdata = d;
         #1;
         n_vec++;
         if (rdata !== m_read(i)) begin
            n_err++; $display("FAIL rand_rdata step %0d idx %0d got %0h want %0h", k, i, rdata, m_read(i));
         end
         n_vec++;
         if (irq !== (m_pend & m_ctrl[2])) begin
            n_err++; $display("FAIL rand_irq step %0d got %b want %b", k, irq, m_pend & m_ctrl[2]);
         end
         @(negedge clk);
      end
      en = 1'b0; we = 1'b0; re = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      test_reset();
      test_count();
      test_wrap();
      test_oneshot();
      test_periodic();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
